// File: rtl/count_tick_ctrl.sv
// count_tick_ctrl: debounced run/pause and clear buttons driving a
// prescaled count-enable tick and a one-cycle clear for a downstream counter.
module count_tick_ctrl #(
  parameter int unsigned CLK_HZ          = 100000000,
  parameter int unsigned TICK_HZ         = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_run,
  input  logic btn_clear,
  output logic tick,
  output logic clear_pulse,
  output logic running
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] PAUSED = 1'b0;
  localparam logic [0:0] RUN    = 1'b1;

  // Button index 0 = run, 1 = clear.
  logic [1:0]    meta_q, sync_q;
  logic [1:0]    deb_q, deb_d;
  logic [1:0]    prev_q, rise_q;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          clear_q, clear_d;

  // Debounce: count consecutive cycles of disagreement, accept on the last one.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          deb_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Run/pause toggle, prescaler and output pulses; clear has priority over tick.
  always_comb begin
    state_d = state_q ^ rise_q[0];
    presc_d = presc_q;
    tick_d  = 1'b0;
    clear_d = rise_q[1];
    if (rise_q[1]) begin
      presc_d = '0;
    end else if (state_q == RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= '0;
      sync_q   <= '0;
      deb_q    <= '0;
      prev_q   <= '0;
      rise_q   <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      state_q  <= PAUSED;
      presc_q  <= '0;
      tick_q   <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      meta_q   <= {btn_clear, btn_run};
      sync_q   <= meta_q;
      deb_q    <= deb_d;
      prev_q   <= deb_q;
      rise_q   <= deb_q & ~prev_q;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      state_q  <= state_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      clear_q  <= clear_d;
    end
  end

  assign tick        = tick_q;
  assign clear_pulse = clear_q;
  assign running     = (state_q == RUN);

endmodule

// File: tb/tb_count_tick_ctrl.sv
// Directed bench for count_tick_ctrl with DIV=10, DEBOUNCE_CYCLES=4.
// Edge index e counts rising edges from the first one; inputs for edge e are
// driven before it and outputs are sampled 1 time unit after it.
module tb_count_tick_ctrl;

  logic clk;
  logic reset;
  logic btn_run;
  logic btn_clear;
  logic tick;
  logic clear_pulse;
  logic running;

  int checks = 0;
  int errors = 0;

  count_tick_ctrl #(
    .CLK_HZ(100),
    .TICK_HZ(10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_run(btn_run),
    .btn_clear(btn_clear),
    .tick(tick),
    .clear_pulse(clear_pulse),
    .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic run;
    logic clr;
    logic rst;
    logic er;
    logic et;
    logic ec;
  } vec_t;

  localparam int NTBL = 144;
  vec_t tbl [NTBL];

  task automatic chk(input string nm, input int e, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b, expected %b", nm, e, act, exp);
    end
  endtask

  task automatic apply(input int e, input logic r, input logic c, input logic rs,
                       input logic er, input logic et, input logic ec);
    btn_run   = r;
    btn_clear = c;
    reset     = rs;
    @(posedge clk);
    #1;
    chk("running", e, running, er);
    chk("tick", e, tick, et);
    chk("clear_pulse", e, clear_pulse, ec);
  endtask

  initial begin
    // Table: reset, 50+ idle cycles, short glitches, then one 20-cycle run press.
    for (int i = 0; i < NTBL; i++) begin
      tbl[i].rst = (i < 3);
      tbl[i].run = ((i >= 53) && (i <= 88) && (((i - 53) % 6) < 3)) ||
                   ((i >= 95) && (i <= 114));
      tbl[i].clr = 1'b0;
      tbl[i].er  = (i >= 102);
      tbl[i].et  = (i >= 112) && (((i - 112) % 10) == 0);
      tbl[i].ec  = 1'b0;
    end

    btn_run   = 1'b0;
    btn_clear = 1'b0;
    reset     = 1'b1;

    for (int i = 0; i < NTBL; i++) begin
      apply(i, tbl[i].run, tbl[i].clr, tbl[i].rst, tbl[i].er, tbl[i].et, tbl[i].ec);
    end

    // Clear one cycle before the tick due at 162, pause at prescaler 6,
    // resume, one-cycle reset at prescaler 8, restart, and a press held
    // through a reset release.
    for (int e = NTBL; e <= 312; e++) begin
      logic r, c, rs, er, et, ec;
      r  = ((e >= 190) && (e <= 195)) || ((e >= 227) && (e <= 232)) ||
           ((e >= 258) && (e <= 263)) || ((e >= 290) && (e <= 300));
      c  = (e >= 154) && (e <= 159);
      rs = (e == 247) || (e == 293);
      er = (e <= 196) || ((e >= 234) && (e <= 246)) ||
           ((e >= 265) && (e <= 292)) || (e >= 301);
      et = (e == 152) || (e == 171) || (e == 181) || (e == 191) ||
           (e == 238) || (e == 275) || (e == 285) || (e == 311);
      ec = (e == 161);
      apply(e, r, c, rs, er, et, ec);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
